seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Programmable controller for the serial pattern detector. It accepts a pattern, length and alarm threshold over a valid/ready configuration handshake, then runs an overlapping Moore-style match on a gated serial stream. It counts detections and halts the stream with an alarm when the threshold is reached. It sits between the bit source and the downstream detection consumer and sequences the detector's configure/run/halt lifecycle.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal range 2..16)
CNT_W, 8, width of the detection counter and threshold

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
cfg_valid  input  1  configuration request
cfg_ready  output  1  controller can accept a configuration
cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit expected, bit 0 the last
cfg_len  input  $clog2(MAX_LEN+1)  pattern length, legal 1..MAX_LEN
cfg_thresh  input  CNT_W  detections before alarm; 0 disables the alarm
cfg_err  output  1  one-cycle pulse when a handshake carried an illegal cfg_len
in_valid  input  1  in_seq is a valid bit this cycle
in_seq  input  1  serial data bit
clr  input  1  clear counter, history and alarm; configuration is kept
det_out  output  1  one-cycle detection pulse (registered)
det_count  output  CNT_W  detections since last config/clr, saturating
alarm  output  1  threshold reached; stays high until clr/config
state_o  output  2  current state encoding, for debug

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; cfg_ready=1, cfg_err=0, det_out=0, det_count=0, alarm=0. History, fill counter and stored configuration are all zeroed. A reset mid-run aborts immediately.
- States:
  - IDLE=0: unconfigured; input bits are ignored.
  - RUN=1: matching.
  - HALT=2: alarm active.
- cfg_ready=1 in IDLE and RUN, 0 in HALT.
- Handshake fires on cfg_valid & cfg_ready.
  - Legal cfg_len: latch pattern, len and thresh; clear history, fill, count and alarm; go to RUN next cycle.
  - cfg_len=0 or >MAX_LEN: pulse cfg_err for 1 cycle; state and stored config unchanged.
- Matching in RUN: on each in_valid cycle, shift in_seq into a MAX_LEN-bit history (LSB = newest). The fill counter increments and saturates at MAX_LEN.
- Match condition: fill >= len and history[len-1:0] == pattern[len-1:0].
- Latency: det_out is high exactly 1 cycle after the clk edge that sampled the final pattern bit, then low.
- Overlap: history is not cleared on a match, so the tail of one match can start the next.
- Counter: det_count increments with each det_out, saturating at 2^CNT_W-1 with no wrap.
- Alarm: if thresh != 0 and det_count reaches thresh, assert alarm in the same cycle det_count updates, and enter HALT.
- In HALT: in_valid is ignored, det_out=0, and det_count holds. clr returns the block to RUN with count, history and fill cleared and alarm=0.
- Priority when events coincide: rst > handshake > clr > in_valid. A bit arriving in the same cycle as a handshake or clr is dropped.
- clr in IDLE has no effect beyond clearing the counters.
- in_valid=0 cycles do not shift the history or change the fill counter; gaps do not break a match.

Decomposition:
- Shared package seq_det_pkg holds:
  - the state enum (IDLE, RUN, HALT)
  - localparam LEN_W = $clog2(MAX_LEN+1)
  - the default MAX_LEN and CNT_W constants
- One sub-module, seq_match_core, holds the history shift register, fill counter and length-masked compare, and outputs a registered match pulse.
- seq_det_ctrl holds the FSM, handshake, counter and alarm logic.

Test Plan:
1. Reset held 2 cycles, then released -> state_o=0, cfg_ready=1, det_out=0, det_count=0, alarm=0.
2. Configure pattern=5'b10110, len=5, thresh=0. Feed 1,0,1,1,0,1,1,0 on consecutive cycles -> det_out pulses 1 cycle after bits 5 and 8 (overlap), det_count=2, alarm stays 0.
3. Same pattern with thresh=2 and the same stream -> alarm=1 and state HALT after the second match. Further bits produce no det_out. clr -> RUN, det_count=0, alarm=0.
4. Handshake with cfg_len=0 and then cfg_len=9 (MAX_LEN=8) -> cfg_err pulses each time, state_o stays 0.
5. In RUN, assert cfg_valid in the same cycle as the final pattern bit -> bit dropped, no det_out, history cleared, new config active.
6. Feed 1,0,1,1 with in_valid gaps between bits, then 0, then assert rst mid-stream -> det_out fires once despite the gaps. After reset, state IDLE and det_count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_pkg : shared types and constants for the sequence detector     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_ctrl_if : configuration, stream and status bundle             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface seq_det_ctrl_if import seq_det_pkg::*; #(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               cfg_err;
    logic               in_valid;
    logic               in_seq;
    logic               clr;
    logic               det_out;
    logic [CNT_W-1:0]   det_count;
    logic               alarm;
    logic [1:0]         state_o;

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_thresh, in_valid, in_seq, clr,
        output cfg_ready, cfg_err, det_out, det_count, alarm, state_o
    );

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_thresh, in_valid, in_seq, clr,
        input  cfg_ready, cfg_err, det_out, det_count, alarm, state_o
    );

endinterface
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_match_core : history shift register with length-masked compare   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_match_core #(
    parameter int MAX_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         shift_i,
    input  logic                         bit_i,
    input  logic [MAX_LEN-1:0]           pattern_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] len_i,
    output logic                         match_o
);
    localparam int            LW    = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [MAX_LEN-1:0] mask;
    logic               match_q;
    logic               hit;

    // Compare against the history as it will be after this shift, so the
    // registered pulse appears one edge after the final bit is sampled.
    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], bit_i};
        fill_d = (fill_q == MAX_L) ? fill_q : fill_q + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_i));
        end
        hit = (fill_d >= len_i) && (((hist_d ^ pattern_i) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= shift_i && hit;
            if (shift_i) begin
                hist_q <= hist_d;
                fill_q <= fill_d;
            end
        end
    end

    assign match_o = match_q;

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_ctrl : configure/run/halt sequencing for the pattern detector |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_det_ctrl import seq_det_pkg::*; #(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_ctrl_if.slave bus
);
    localparam int            LW    = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               alarm_q, alarm_d;
    logic               det_q, det_d;
    logic               err_q, err_d;

    logic ready, fire, len_ok, core_clr, shift, match, det_ev;

    assign ready    = (state_q != ST_HALT);
    assign fire     = bus.cfg_valid && ready;
    assign len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_L);
    // A handshake of either kind swallows clr and the data bit of its cycle.
    assign core_clr = (fire && len_ok) || (!fire && bus.clr);
    assign shift    = bus.in_valid && (state_q == ST_RUN) && !fire && !bus.clr;
    assign det_ev   = match && (state_q == ST_RUN) && !fire && !bus.clr;

    seq_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (core_clr),
        .shift_i   (shift),
        .bit_i     (bus.in_seq),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .match_o   (match)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        det_d   = 1'b0;
        err_d   = 1'b0;
        if (fire) begin
            if (len_ok) begin
                pat_d   = bus.cfg_pattern;
                len_d   = bus.cfg_len;
                thr_d   = bus.cfg_thresh;
                cnt_d   = '0;
                alarm_d = 1'b0;
                state_d = ST_RUN;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.clr) begin
            cnt_d   = '0;
            alarm_d = 1'b0;
            if (state_q == ST_HALT) begin
                state_d = ST_RUN;
            end
        end else if (det_ev) begin
            det_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((thr_q != '0) && (cnt_d == thr_q)) begin
                alarm_d = 1'b1;
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            det_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            det_q   <= det_d;
            err_q   <= err_d;
        end
    end

    assign bus.cfg_ready = ready;
    assign bus.cfg_err   = err_q;
    assign bus.det_out   = det_q;
    assign bus.det_count = cnt_q;
    assign bus.alarm     = alarm_q;
    assign bus.state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_det_ctrl : directed bench with a bit-queue reference model     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_seq_det_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the raw list of accepted bits since the last clear
    int                 m_state, m_len, m_thr, m_cnt;
    logic [MAX_LEN-1:0] m_pat;
    bit                 m_alarm, m_det, m_err, m_pend;
    bit                 m_live = 1'b0;
    bit                 m_q[$];

    always @(posedge clk) begin : model
        bit fire, legal, hit, run_prev;
        if (!rst) begin
            m_state = 0; m_pat = '0; m_len = 0; m_thr = 0; m_cnt = 0;
            m_alarm = 0; m_det = 0; m_err = 0; m_pend = 0;
            m_q.delete();
        end else begin
            m_det = 0;
            m_err = 0;
            fire  = bus.cfg_valid && (m_state != 2);
            legal = (bus.cfg_len >= 1) && (bus.cfg_len <= MAX_LEN);
            if (fire) begin
                m_pend = 0;
                if (legal) begin
                    m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
                    m_thr = int'(bus.cfg_thresh); m_cnt = 0; m_alarm = 0;
                    m_state = 1; m_q.delete();
                end else begin
                    m_err = 1;
                end
            end else if (bus.clr) begin
                m_cnt = 0; m_alarm = 0; m_pend = 0; m_q.delete();
                if (m_state == 2) m_state = 1;
            end else begin
                run_prev = (m_state == 1);
                if (run_prev && m_pend) begin
                    m_det = 1;
                    if (m_cnt < CMAX) m_cnt++;
                    if (m_thr != 0 && m_cnt == m_thr) begin
                        m_alarm = 1;
                        m_state = 2;
                    end
                end
                m_pend = 0;
                if (run_prev && bus.in_valid) begin
                    m_q.push_back(bus.in_seq);
                    if (m_q.size() > 64) void'(m_q.pop_front());
                    hit = (m_q.size() >= m_len);
                    for (int k = 0; k < m_len; k++)
                        if (hit && (m_q[m_q.size() - 1 - k] != m_pat[k])) hit = 0;
                    m_pend = hit;
                end
            end
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin : compare
        if (m_live) begin
            check("state_o",   int'(bus.state_o),   m_state);
            check("cfg_ready", int'(bus.cfg_ready), int'(m_state != 2));
            check("det_out",   int'(bus.det_out),   int'(m_det));
            check("det_count", int'(bus.det_count), m_cnt);
            check("alarm",     int'(bus.alarm),     int'(m_alarm));
            check("cfg_err",   int'(bus.cfg_err),   int'(m_err));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] pat, input int len, input int thr);
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = LW'(len);
        bus.cfg_thresh  = CNT_W'(thr);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic bit_in(input logic b);
        bus.in_valid = 1'b1;
        bus.in_seq   = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    logic [7:0] stream;
    logic [7:0] exp_det;

    initial begin
        bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_thresh = '0;
        bus.in_valid = 0; bus.in_seq = 0; bus.clr = 0;
        stream  = 8'b1011_0110;   // sent MSB first: 1,0,1,1,0,1,1,0
        exp_det = 8'b0000_0100;   // det after bit 6 (first match); second lands after bit 8

        // Reset and idle state
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("t1_state", int'(bus.state_o), 0);
        check("t1_ready", int'(bus.cfg_ready), 1);
        check("t1_count", int'(bus.det_count), 0);
        check("t1_alarm", int'(bus.alarm), 0);

        // Illegal lengths in IDLE
        cfg(8'h16, 0, 0);
        check("t4_err0", int'(bus.cfg_err), 1);
        check("t4_state0", int'(bus.state_o), 0);
        step();
        check("t4_errlow", int'(bus.cfg_err), 0);
        cfg(8'h16, 9, 0);
        check("t4_err9", int'(bus.cfg_err), 1);
        check("t4_state9", int'(bus.state_o), 0);
        do_clr();
        bit_in(1'b1);
        check("t4_idle_ignore", int'(bus.state_o), 0);

        // Overlapping detection, no alarm
        cfg(8'b0001_0110, 5, 0);
        check("t2_run", int'(bus.state_o), 1);
        for (int i = 7; i >= 0; i--) begin
            bit_in(stream[i]);
            check("t2_det_seq", int'(bus.det_out), int'(exp_det[i]));
        end
        step();
        check("t2_det_last", int'(bus.det_out), 1);
        check("t2_count", int'(bus.det_count), 2);
        step();
        check("t2_det_low", int'(bus.det_out), 0);
        check("t2_alarm", int'(bus.alarm), 0);

        // Threshold of 2 halts after the second match
        cfg(8'b0001_0110, 5, 2);
        for (int i = 7; i >= 0; i--) bit_in(stream[i]);
        step();
        check("t3_alarm", int'(bus.alarm), 1);
        check("t3_halt", int'(bus.state_o), 2);
        check("t3_ready", int'(bus.cfg_ready), 0);
        for (int i = 7; i >= 0; i--) bit_in(stream[i]);
        cfg(8'h03, 2, 0);
        step();
        check("t3_hold_count", int'(bus.det_count), 2);
        check("t3_halt_ignore_cfg", int'(bus.state_o), 2);
        do_clr();
        check("t3_clr_state", int'(bus.state_o), 1);
        check("t3_clr_count", int'(bus.det_count), 0);
        check("t3_clr_alarm", int'(bus.alarm), 0);

        // Handshake coinciding with the final pattern bit
        cfg(8'b0000_0101, 3, 0);
        bit_in(1'b1);
        bit_in(1'b0);
        bus.in_valid = 1'b1; bus.in_seq = 1'b1;
        cfg(8'b0000_0011, 2, 0);
        bus.in_valid = 1'b0;
        step();
        check("t5_dropped", int'(bus.det_out), 0);
        bit_in(1'b1);
        step();
        check("t5_hist_clear", int'(bus.det_out), 0);
        bit_in(1'b1);
        step();
        check("t5_new_cfg", int'(bus.det_out), 1);

        // Threshold of 1 halts on the very first detection
        cfg(8'b0000_0001, 2, 1);
        bit_in(1'b0);
        bit_in(1'b1);
        step();
        check("t7_thr1_alarm", int'(bus.alarm), 1);
        check("t7_thr1_count", int'(bus.det_count), 1);
        do_clr();

        // Counter saturation: '11' overlaps on every bit after the first
        cfg(8'b0000_0011, 2, 0);
        for (int i = 0; i < 260; i++) bit_in(1'b1);
        step();
        check("t8_saturate", int'(bus.det_count), CMAX);
        check("t8_no_alarm", int'(bus.alarm), 0);

        // Gaps between bits, then reset mid-stream
        cfg(8'b0000_1011, 4, 0);
        bit_in(1'b1); step(); step();
        bit_in(1'b0); step();
        bit_in(1'b1); step();
        bit_in(1'b1);
        step();
        check("t6_gap_det", int'(bus.det_out), 1);
        check("t6_gap_count", int'(bus.det_count), 1);
        bit_in(1'b0);
        bus.in_valid = 1'b1; bus.in_seq = 1'b1;
        rst = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("t6_rst_state", int'(bus.state_o), 0);
        check("t6_rst_count", int'(bus.det_count), 0);
        check("t6_rst_ready", int'(bus.cfg_ready), 1);
        rst = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
